// File: rtl/idli_sqi_mem.sv
// Bench-side model of CHANNELS independent SQI serial SRAMs in sequential mode.
// Each channel decodes READ (0x03) / WRITE (0x02) streams against its own byte array.
module idli_sqi_mem #(
  parameter int CHANNELS      = 2,
  parameter int ADDR_W        = 16,
  parameter int DEPTH_BYTES   = 65536,
  parameter int DUMMY_NIBBLES = 2
) (
  input  logic                                                i_mem_gck,
  input  logic                                                i_mem_rst,
  input  logic [CHANNELS-1:0]                                 i_mem_sck,
  input  logic [CHANNELS-1:0]                                 i_mem_cs,
  input  logic [4*CHANNELS-1:0]                               i_mem_sio,
  output logic [4*CHANNELS-1:0]                               o_mem_sio,
  output logic [CHANNELS-1:0]                                 o_mem_sio_oe,
  output logic [CHANNELS-1:0]                                 o_mem_err,
  input  logic                                                i_mem_bd_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]  i_mem_bd_ch,
  input  logic [$clog2(DEPTH_BYTES)-1:0]                      i_mem_bd_addr,
  input  logic [7:0]                                          i_mem_bd_data
);

  localparam int AW       = $clog2(DEPTH_BYTES);
  localparam int ADDR_NIB = ADDR_W / 4;

  typedef enum logic [2:0] {S_CMD, S_ADDR, S_DUMMY, S_RD, S_WR, S_IGNORE} state_t;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t         state;
    logic [7:0]     cnt;
    logic [3:0]     nib;
    logic [3:0]     cmd_hi;
    logic [3:0]     hi_nib;
    logic [3:0]     sio_q;
    logic [3:0]     rd_nib;
    logic           wr_mode;
    logic           lo_sel;
    logic           rd_lo;
    logic           oe_q;
    logic           err_q;
    logic           beat;
    logic           sqi_we;
    logic           bd_hit;
    logic [AW-1:0]  addr;
    logic [AW-1:0]  addr_asm;
    logic [AW-1:0]  rd_addr;
    logic [7:0]     rd_byte;
    logic [7:0]     mem [DEPTH_BYTES];

    assign nib      = i_mem_sio[4*c +: 4];
    assign beat     = !i_mem_cs[c] && i_mem_sck[c];
    // Shifting into an AW-wide register drops the address bits above the array depth.
    assign addr_asm = AW'({addr, nib});
    assign sqi_we   = beat && (state == S_WR) && (cnt != 8'd0);
    assign bd_hit   = i_mem_bd_we && (int'(i_mem_bd_ch) == c);

    // Read pointer as it will stand after this edge; the output register follows it.
    always_comb begin
      rd_addr = addr;
      rd_lo   = lo_sel;
      case (state)
        S_ADDR: begin
          rd_addr = addr_asm;
          rd_lo   = 1'b0;
        end
        S_RD: begin
          if (beat) begin
            if (lo_sel) begin
              rd_addr = addr + AW'(1);
              rd_lo   = 1'b0;
            end else begin
              rd_lo = 1'b1;
            end
          end
        end
        default: ;
      endcase
      rd_byte = mem[rd_addr];
      rd_nib  = rd_lo ? rd_byte[3:0] : rd_byte[7:4];
    end

    always_ff @(posedge i_mem_gck or posedge i_mem_rst) begin
      if (i_mem_rst) begin
        state <= S_CMD;
        cnt   <= '0;
        sio_q <= '0;
        oe_q  <= 1'b0;
        err_q <= 1'b0;
      end else if (i_mem_cs[c]) begin
        state <= S_CMD;
        cnt   <= '0;
        oe_q  <= 1'b0;
      end else begin
        case (state)
          S_CMD: if (beat) begin
            if (cnt == 8'd0) begin
              cnt <= 8'd1;
            end else begin
              cnt <= '0;
              if (({cmd_hi, nib} == 8'h03) || ({cmd_hi, nib} == 8'h02)) begin
                state <= S_ADDR;
              end else begin
                err_q <= 1'b1;
                state <= S_IGNORE;
              end
            end
          end
          S_ADDR: if (beat) begin
            if (cnt == 8'(ADDR_NIB - 1)) begin
              cnt <= '0;
              if (wr_mode) begin
                state <= S_WR;
              end else if (DUMMY_NIBBLES == 0) begin
                state <= S_RD;
                oe_q  <= 1'b1;
                sio_q <= rd_nib;
              end else begin
                state <= S_DUMMY;
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          S_DUMMY: if (beat) begin
            if (cnt == 8'(DUMMY_NIBBLES - 1)) begin
              cnt   <= '0;
              state <= S_RD;
              oe_q  <= 1'b1;
              sio_q <= rd_nib;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          S_RD: begin
            oe_q  <= 1'b1;
            sio_q <= rd_nib;
          end
          S_WR: if (beat) begin
            cnt <= (cnt == 8'd0) ? 8'd1 : 8'd0;
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge i_mem_gck) begin
      if (beat) begin
        case (state)
          S_CMD: begin
            if (cnt == 8'd0) cmd_hi <= nib;
            else             wr_mode <= ({cmd_hi, nib} == 8'h02);
          end
          S_ADDR: begin
            addr   <= addr_asm;
            lo_sel <= 1'b0;
          end
          S_WR: begin
            if (cnt == 8'd0) hi_nib <= nib;
            else             addr   <= addr + AW'(1);
          end
          default: ;
        endcase
      end
      if (state == S_RD) begin
        addr   <= rd_addr;
        lo_sel <= rd_lo;
      end
    end

    // Backdoor is written last so it wins a same-byte collision with an SQI write.
    always_ff @(posedge i_mem_gck) begin
      if (sqi_we) mem[addr] <= {hi_nib, nib};
      if (bd_hit) mem[i_mem_bd_addr] <= i_mem_bd_data;
    end

    assign o_mem_sio[4*c +: 4] = sio_q;
    assign o_mem_sio_oe[c]     = oe_q;
    assign o_mem_err[c]        = err_q;
  end

endmodule

// File: tb/tb_idli_sqi_mem.sv
// Directed bench for idli_sqi_mem: table of write/read transactions plus
// hand-written sequences for bad commands, aborted writes, reset and backdoor collisions.
module tb_idli_sqi_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sck;
  logic [1:0]  cs;
  logic [7:0]  sio_in;
  logic [7:0]  sio_out;
  logic [1:0]  oe;
  logic [1:0]  err;
  logic        bd_we;
  logic [0:0]  bd_ch;
  logic [15:0] bd_addr;
  logic [7:0]  bd_data;

  int checks = 0;
  int fails  = 0;

  idli_sqi_mem #(
    .CHANNELS(2), .ADDR_W(16), .DEPTH_BYTES(65536), .DUMMY_NIBBLES(2)
  ) dut (
    .i_mem_gck(clk), .i_mem_rst(rst), .i_mem_sck(sck), .i_mem_cs(cs),
    .i_mem_sio(sio_in), .o_mem_sio(sio_out), .o_mem_sio_oe(oe), .o_mem_err(err),
    .i_mem_bd_we(bd_we), .i_mem_bd_ch(bd_ch), .i_mem_bd_addr(bd_addr),
    .i_mem_bd_data(bd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  d0;
    logic [7:0]  d1;
    int          n;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All tasks start and end just after a falling clock edge.
  task automatic beat(input int ch, input logic [3:0] n);
    sck[ch] = 1'b1;
    sio_in[4*ch +: 4] = n;
    @(negedge clk);
    sck[ch] = 1'b0;
  endtask

  task automatic beat_both(input logic [3:0] n0, input logic [3:0] n1);
    sck = 2'b11;
    sio_in = {n1, n0};
    @(negedge clk);
    sck = 2'b00;
  endtask

  task automatic bd(input int ch, input logic [15:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_ch = 1'(ch); bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic send_hdr(input int ch, input logic [7:0] cmd, input logic [15:0] a);
    cs[ch] = 1'b0;
    beat(ch, cmd[7:4]);
    beat(ch, cmd[3:0]);
    for (int i = 3; i >= 0; i--) beat(ch, a[4*i +: 4]);
  endtask

  task automatic end_tx(input int ch);
    cs[ch] = 1'b1;
    @(negedge clk);
    check($sformatf("oe drop ch%0d", ch), 32'(oe[ch]), 32'd0);
  endtask

  task automatic wr_tx(input int ch, input logic [15:0] a, input logic [7:0] d0,
                       input logic [7:0] d1, input int n);
    send_hdr(ch, 8'h02, a);
    beat(ch, d0[7:4]);
    beat(ch, d0[3:0]);
    if (n > 1) begin
      beat(ch, d1[7:4]);
      beat(ch, d1[3:0]);
    end
    end_tx(ch);
  endtask

  task automatic rd_body(input int ch, input logic [15:0] a, input logic [7:0] d0,
                         input logic [7:0] d1, input int n);
    logic [15:0] exp;
    exp = {d0, d1};
    check($sformatf("oe rd ch%0d @%h", ch, a), 32'(oe[ch]), 32'd1);
    for (int k = 0; k < 2*n; k++) begin
      check($sformatf("rd ch%0d @%h nib%0d", ch, a, k), 32'(sio_out[4*ch +: 4]),
            32'(exp[15-4*k -: 4]));
      beat(ch, 4'h0);
    end
    end_tx(ch);
  endtask

  task automatic rd_tx(input int ch, input logic [15:0] a, input logic [7:0] d0,
                       input logic [7:0] d1, input int n);
    send_hdr(ch, 8'h03, a);
    beat(ch, 4'h0);
    beat(ch, 4'h0);
    rd_body(ch, a, d0, d1, n);
  endtask

  task automatic wr_both(input logic [15:0] a, input bit coll);
    cs = 2'b00;
    beat_both(4'h0, 4'h0);
    beat_both(4'h2, 4'h2);
    for (int i = 3; i >= 0; i--) beat_both(a[4*i +: 4], a[4*i +: 4]);
    beat_both(4'h1, 4'h2);
    if (coll) begin
      bd_we = 1'b1; bd_ch = 1'b1; bd_addr = a; bd_data = 8'h7E;
    end
    beat_both(4'h1, 4'h2);
    bd_we = 1'b0;
    cs = 2'b11;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; sck = '0; cs = 2'b11; sio_in = '0;
    bd_we = 1'b0; bd_ch = '0; bd_addr = '0; bd_data = '0;
    vecs[0] = '{ch: 0, wr: 1'b1, addr: 16'h0010, d0: 8'hA5, d1: 8'h3C, n: 2};
    vecs[1] = '{ch: 0, wr: 1'b0, addr: 16'h0010, d0: 8'hA5, d1: 8'h3C, n: 2};
    vecs[2] = '{ch: 0, wr: 1'b1, addr: 16'hFFFF, d0: 8'h11, d1: 8'h22, n: 2};
    vecs[3] = '{ch: 0, wr: 1'b0, addr: 16'hFFFF, d0: 8'h11, d1: 8'h22, n: 2};
    vecs[4] = '{ch: 0, wr: 1'b0, addr: 16'h0000, d0: 8'h22, d1: 8'h00, n: 1};
    vecs[5] = '{ch: 1, wr: 1'b1, addr: 16'h0020, d0: 8'h5A, d1: 8'h00, n: 1};
    vecs[6] = '{ch: 1, wr: 1'b0, addr: 16'h0020, d0: 8'h5A, d1: 8'h00, n: 1};
    vecs[7] = '{ch: 1, wr: 1'b0, addr: 16'h0040, d0: 8'h00, d1: 8'h00, n: 1};

    repeat (3) @(negedge clk);
    check("reset sio", 32'(sio_out), 32'h0);
    check("reset oe", 32'(oe), 32'h0);
    check("reset err", 32'(err), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    bd(1, 16'h0040, 8'h00);
    bd(0, 16'h0030, 8'h00);

    // Unknown command on ch1: rest of the transaction must be ignored.
    cs[1] = 1'b0;
    beat(1, 4'hF);
    beat(1, 4'hF);
    check("err after bad cmd", 32'(err), 32'h2);
    beat(1, 4'h0); beat(1, 4'h0); beat(1, 4'h4); beat(1, 4'h0);
    beat(1, 4'h9); beat(1, 4'h9);
    check("oe during ignore", 32'(oe[1]), 32'd0);
    end_tx(1);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].wr) wr_tx(vecs[v].ch, vecs[v].addr, vecs[v].d0, vecs[v].d1, vecs[v].n);
      else            rd_tx(vecs[v].ch, vecs[v].addr, vecs[v].d0, vecs[v].d1, vecs[v].n);
    end
    check("err sticky after table", 32'(err), 32'h2);

    // Aborted write: a lone data nibble must be discarded.
    send_hdr(0, 8'h02, 16'h0030);
    beat(0, 4'h7);
    cs[0] = 1'b1;
    @(negedge clk);
    rd_tx(0, 16'h0030, 8'h00, 8'h00, 1);
    check("err after abort", 32'(err), 32'h2);

    // Asynchronous reset in the middle of a read.
    send_hdr(0, 8'h03, 16'h0010);
    beat(0, 4'h0);
    beat(0, 4'h0);
    check("mid-read nib0", 32'(sio_out[3:0]), 32'hA);
    beat(0, 4'h0);
    check("mid-read nib1", 32'(sio_out[3:0]), 32'h5);
    #2 rst = 1'b1;
    #1;
    check("async rst oe", 32'(oe), 32'h0);
    check("async rst sio", 32'(sio_out), 32'h0);
    check("async rst err", 32'(err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd_tx(0, 16'h0010, 8'hA5, 8'h3C, 2);

    // Backdoor vs SQI writes.
    bd(1, 16'h0005, 8'h7E);
    wr_both(16'h0005, 1'b0);
    rd_tx(0, 16'h0005, 8'h11, 8'h00, 1);
    rd_tx(1, 16'h0005, 8'h22, 8'h00, 1);
    wr_both(16'h0005, 1'b1);
    rd_tx(1, 16'h0005, 8'h7E, 8'h00, 1);
    rd_tx(0, 16'h0005, 8'h11, 8'h00, 1);
    check("err final", 32'(err), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/idli_sqi_mem.md
Name: idli_sqi_mem

Overview:
Parametrised bench-side SQI serial-SRAM model. It sits opposite the core's SQI pins and replaces fixed hi/lo wiring with CHANNELS independent devices. Each channel decodes a READ/WRITE command stream in sequential mode against its own byte array. A backdoor port lets the bench preload memory.

Parameters:
CHANNELS, 2, number of independent SQI devices (>=1); channel 0 = lo, 1 = hi
ADDR_W, 16, address bits sent per transaction; multiple of 4, so ADDR_W/4 address nibbles
DEPTH_BYTES, 65536, bytes per channel; power of two, <= 2**ADDR_W
DUMMY_NIBBLES, 2, dummy beats between address and read data

Ports:
i_mem_gck  in  1  clock
i_mem_rst  in  1  asynchronous reset, active-high
i_mem_sck  in  CHANNELS  per-channel serial clock; high in a gck cycle = one beat
i_mem_cs  in  CHANNELS  per-channel chip select, active-low
i_mem_sio  in  4*CHANNELS  nibble from core; channel c at bits [4c+3:4c]
o_mem_sio  out  4*CHANNELS  nibble to core, same packing
o_mem_sio_oe  out  CHANNELS  high while the channel drives read data
o_mem_err  out  CHANNELS  sticky: unknown command seen
i_mem_bd_we  in  1  backdoor byte write
i_mem_bd_ch  in  max(1,$clog2(CHANNELS))  backdoor channel
i_mem_bd_addr  in  $clog2(DEPTH_BYTES)  backdoor byte address
i_mem_bd_data  in  8  backdoor byte

Behaviour:
- Beat: rising gck edge with cs[c]=0 and sck[c]=1. All channel logic advances only on beats. Channels are fully independent (generate loop).
- Reset (async, any time): every FSM goes to CMD; nibble counters clear; o_mem_sio=0, o_mem_sio_oe=0, o_mem_err=0. Memory contents are not reset. Memory is zero at time 0.
- cs[c] sampled high: FSM returns to CMD and counters clear in that cycle, regardless of sck. oe drops the next cycle. An incomplete write byte (one nibble) is discarded. err is unaffected.
- FSM per channel:
  - CMD: 2 beats, high nibble first. 0x03 goes to ADDR (read). 0x02 goes to ADDR (write). Any other value sets err[c] and goes to IGNORE.
  - ADDR: ADDR_W/4 beats, MS nibble first. Address bits above $clog2(DEPTH_BYTES) are dropped. Read goes to DUMMY (or RD if DUMMY_NIBBLES=0). Write goes to WR.
  - DUMMY: DUMMY_NIBBLES beats, input ignored, then RD.
  - RD: oe=1. On the cycle after entering RD, o_sio holds the high nibble of mem[addr]. Each beat advances to the low nibble, then to the high nibble of addr+1. Output is registered and held between beats.
  - WR: first beat latches the high nibble. Second beat writes {hi,lo} to mem[addr] at that edge and increments addr.
  - IGNORE: all beats ignored until cs goes high.
- Address increment wraps modulo DEPTH_BYTES (0xFFFF+1 -> 0x0000 at default). Transactions stream indefinitely.
- Backdoor: single-cycle synchronous write to mem[bd_ch][bd_addr]. If it hits the same byte as an SQI write in the same cycle, the backdoor wins. A bd_ch >= CHANNELS is ignored.
- Read of a byte written in the previous cycle returns the new value; no read-during-write hazard across beats.
- err is sticky until reset and does not block later valid transactions.

Test Plan:
1. Assert rst mid-read with oe=1 -> o_mem_sio_oe=0, o_mem_sio=0, o_mem_err=0 immediately (async); the next transaction decodes from CMD.
2. ch0: cmd 02, addr 0010, data A5 3C, cs high; then cmd 03, addr 0010, 2 dummy beats, 4 beats -> oe=1, o_sio[3:0] sequence A,5,3,C.
3. ch0: write at addr FFFF, bytes 11 22 -> read addr FFFF returns 11 then 22; read addr 0000 returns 22.
4. ch1: cmd FF -> err[1]=1, oe[1] stays 0, no memory change. Then a valid write/read of 5A at 0020 succeeds while err[1] stays 1 and err[0]=0.
5. ch0: cmd 02, addr 0030, one data nibble 7, cs high -> mem[0030] unchanged (0). Next cs-low beats decode as a command.
6. Backdoor ch1 addr 0005 = 7E. Same-cycle SQI writes ch0 addr 0005=11 and ch1 addr 0005=22. Reads return ch0=11 and ch1=22. Repeat ch1 with the backdoor (7E) and the SQI write of 22 colliding -> ch1 reads 7E.
